// File: rtl/alu_sequencer.sv
// Multi-pass controller: runs the 8-bit ALU once (8-bit ops) or twice (16-bit ops) and assembles RES/ZNHC flags.
// Latency: DONE 2 cycles after an accepted REQ for ops 0-3, 3 cycles for ops 4-7; RES/FLAGS_OUT held until next completion.
// Backpressure: REQ is accepted only while BUSY=0; a REQ seen while BUSY=1 is dropped with no side effects.
//
// Ports: CLK/nRESET (async active-low); REQ/OP/OPA/OPB/FLAGS_IN request side; BUSY/DONE/RES/FLAGS_OUT result side;
//        ALU_A/ALU_B/ALU_CIN/ALU_SUB drive the external 8-bit ALU, ALU_RES/ALU_COUT/ALU_HOUT return from it.
// Optional build macro ALU_SEQ_BACK2BACK_EN: BUSY drops in FIN so a new REQ can be taken while DONE is high.

module alu_sequencer (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        REQ,
    input  logic [2:0]  OP,
    input  logic [15:0] OPA,
    input  logic [15:0] OPB,
    input  logic [3:0]  FLAGS_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RES,
    output logic [3:0]  FLAGS_OUT,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic        ALU_CIN,
    output logic        ALU_SUB,
    input  logic [7:0]  ALU_RES,
    input  logic        ALU_COUT,
    input  logic        ALU_HOUT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [2:0] OP_ADD8  = 3'd0;
    localparam logic [2:0] OP_ADC8  = 3'd1;
    localparam logic [2:0] OP_SUB8  = 3'd2;
    localparam logic [2:0] OP_SBC8  = 3'd3;
    localparam logic [2:0] OP_ADD16 = 3'd4;
    localparam logic [2:0] OP_INC16 = 3'd5;
    localparam logic [2:0] OP_DEC16 = 3'd6;
    localparam logic [2:0] OP_ADDSP = 3'd7;

    logic [1:0]  state;
    logic [2:0]  op_q;
    logic [15:0] opa_q;
    logic [15:0] opb_q;
    logic [3:0]  flags_q;
    logic [7:0]  res_lo_q;
    logic        lo_h_q;
    logic        lo_c_q;

    logic        fin_busy;
    logic        accept;
    logic        is_16bit_op;

`ifdef ALU_SEQ_BACK2BACK_EN
    // FIN is a free slot: the next request overlaps the DONE cycle.
    assign fin_busy = 1'b0;
`else
    assign fin_busy = 1'b1;
`endif

    assign BUSY        = (state == ST_LO) || (state == ST_HI) || ((state == ST_FIN) && fin_busy);
    assign DONE        = (state == ST_FIN);
    assign accept      = REQ && !BUSY;
    assign is_16bit_op = op_q[2];

    // ALU drive is purely a function of state and the latched request.
    always_comb begin
        ALU_A   = 8'h00;
        ALU_B   = 8'h00;
        ALU_CIN = 1'b0;
        ALU_SUB = 1'b0;
        case (state)
            ST_LO: begin
                ALU_A   = opa_q[7:0];
                ALU_B   = ((op_q == OP_INC16) || (op_q == OP_DEC16)) ? 8'h01 : opb_q[7:0];
                ALU_CIN = ((op_q == OP_ADC8) || (op_q == OP_SBC8)) ? flags_q[0] : 1'b0;
                ALU_SUB = (op_q == OP_SUB8) || (op_q == OP_SBC8) || (op_q == OP_DEC16);
            end
            ST_HI: begin
                ALU_A   = opa_q[15:8];
                ALU_CIN = lo_c_q;
                ALU_SUB = (op_q == OP_DEC16);
                case (op_q)
                    OP_ADD16: ALU_B = opb_q[15:8];
                    // ADD SP,e: e is signed, so the high byte adds its sign extension.
                    OP_ADDSP: ALU_B = {8{opb_q[7]}};
                    default:  ALU_B = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= ST_IDLE;
            op_q      <= 3'd0;
            opa_q     <= 16'h0000;
            opb_q     <= 16'h0000;
            flags_q   <= 4'h0;
            res_lo_q  <= 8'h00;
            lo_h_q    <= 1'b0;
            lo_c_q    <= 1'b0;
            RES       <= 16'h0000;
            FLAGS_OUT <= 4'h0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    // In FIN, accept can only be true when FIN is not busy.
                    if (accept) begin
                        op_q    <= OP;
                        opa_q   <= OPA;
                        opb_q   <= OPB;
                        flags_q <= FLAGS_IN;
                        state   <= ST_LO;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_LO: begin
                    res_lo_q <= ALU_RES;
                    lo_h_q   <= ALU_HOUT;
                    lo_c_q   <= ALU_COUT;
                    if (is_16bit_op) begin
                        state <= ST_HI;
                    end else begin
                        // 8-bit ops finish here; RES is only written on FIN entry
                        // so the previous result stays visible until now.
                        state     <= ST_FIN;
                        RES       <= {8'h00, ALU_RES};
                        FLAGS_OUT <= {(ALU_RES == 8'h00),
                                      ((op_q == OP_SUB8) || (op_q == OP_SBC8)),
                                      ALU_HOUT,
                                      ALU_COUT};
                    end
                end
                ST_HI: begin
                    state <= ST_FIN;
                    RES   <= {ALU_RES, res_lo_q};
                    case (op_q)
                        OP_ADD16: FLAGS_OUT <= {flags_q[3], 1'b0, ALU_HOUT, ALU_COUT};
                        // ADD SP,e reports byte-level H/C from the low pass.
                        OP_ADDSP: FLAGS_OUT <= {2'b00, lo_h_q, lo_c_q};
                        default:  FLAGS_OUT <= flags_q;
                    endcase
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: external ALU model, randomized requests, per-cycle compare against an arithmetic reference.
// Latency: n/a.
// Backpressure: bench tracks when the sequencer may accept and expects dropped requests to vanish.

module tb_alu_sequencer;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b1;
    logic        REQ = 1'b0;
    logic [2:0]  OP = 3'd0;
    logic [15:0] OPA = 16'h0000;
    logic [15:0] OPB = 16'h0000;
    logic [3:0]  FLAGS_IN = 4'h0;
    logic        BUSY;
    logic        DONE;
    logic [15:0] RES;
    logic [3:0]  FLAGS_OUT;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic        ALU_CIN;
    logic        ALU_SUB;
    logic [7:0]  ALU_RES;
    logic        ALU_COUT;
    logic        ALU_HOUT;

`ifdef ALU_SEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    alu_sequencer dut (
        .CLK(CLK), .nRESET(nRESET), .REQ(REQ), .OP(OP), .OPA(OPA), .OPB(OPB),
        .FLAGS_IN(FLAGS_IN), .BUSY(BUSY), .DONE(DONE), .RES(RES), .FLAGS_OUT(FLAGS_OUT),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN), .ALU_SUB(ALU_SUB),
        .ALU_RES(ALU_RES), .ALU_COUT(ALU_COUT), .ALU_HOUT(ALU_HOUT)
    );

    always #5 CLK = ~CLK;

    // External 8-bit ALU: A+B+CIN or A-B-CIN, with carry/borrow out of bits 7 and 3.
    logic [8:0] alu_s;
    logic [4:0] alu_h;
    always_comb begin
        alu_s = 9'h000;
        alu_h = 5'h00;
        if (ALU_SUB) begin
            alu_s = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'h00, ALU_CIN};
            alu_h = {1'b0, ALU_A[3:0]} - {1'b0, ALU_B[3:0]} - {4'h0, ALU_CIN};
        end else begin
            alu_s = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'h00, ALU_CIN};
            alu_h = {1'b0, ALU_A[3:0]} + {1'b0, ALU_B[3:0]} + {4'h0, ALU_CIN};
        end
    end
    assign ALU_RES  = alu_s[7:0];
    assign ALU_COUT = alu_s[8];
    assign ALU_HOUT = alu_h[4];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference state: the one request in flight and the result currently on display.
    int          cyc = 0;
    bit          active = 1'b0;
    int          start_c = 0;
    int          due_c = 0;
    logic [2:0]  l_op = 3'd0;
    logic [15:0] l_a = 16'h0000;
    logic [15:0] l_b = 16'h0000;
    logic [3:0]  l_f = 4'h0;
    logic [15:0] pend_res = 16'h0000;
    logic [3:0]  pend_fl = 4'h0;
    logic [15:0] held_res = 16'h0000;
    logic [3:0]  held_fl = 4'h0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Whole-word arithmetic reference: returns {RES, Z, N, H, C}.
    function automatic logic [19:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] f);
        int r, ia, ib, cc, sb;
        logic z, n, h, c;
        ia = int'(a);
        ib = int'(b);
        cc = ((op == 3'd1) || (op == 3'd3)) ? int'(f[0]) : 0;
        r = 0; sb = 0; z = 1'b0; n = 1'b0; h = 1'b0; c = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                r = (ia & 255) + (ib & 255) + cc;
                h = ((ia & 15) + (ib & 15) + cc) > 15;
                c = r > 255;
                r = r & 255;
                z = (r == 0);
            end
            3'd2, 3'd3: begin
                r = (ia & 255) - (ib & 255) - cc;
                h = ((ia & 15) - (ib & 15) - cc) < 0;
                c = r < 0;
                r = r & 255;
                z = (r == 0);
                n = 1'b1;
            end
            3'd4: begin
                r = ia + ib;
                h = ((ia & 4095) + (ib & 4095)) > 4095;
                c = r > 65535;
                z = f[3];
            end
            3'd5: begin r = ia + 1; {z, n, h, c} = f; end
            3'd6: begin r = ia - 1; {z, n, h, c} = f; end
            default: begin
                sb = (ib & 255) - (((ib & 128) != 0) ? 256 : 0);
                r = ia + sb;
                h = ((ia & 15) + (ib & 15)) > 15;
                c = ((ia & 255) + (ib & 255)) > 255;
            end
        endcase
        r = r & 65535;
        return {r[15:0], z, n, h, c};
    endfunction

    function automatic bit model_busy(input int c);
        return active && (c >= start_c) && ((c < due_c) || ((c == due_c) && !B2B));
    endfunction

    task automatic model_reset();
        active   = 1'b0;
        held_res = 16'h0000;
        held_fl  = 4'h0;
    endtask

    // Advance one clock and update the reference from what the DUT sampled at the edge.
    task automatic tick();
        bit busy_old;
        @(posedge CLK);
        #1;
        busy_old = model_busy(cyc);
        cyc++;
        if (!nRESET) begin
            model_reset();
        end else if (REQ && !busy_old) begin
            l_op = OP; l_a = OPA; l_b = OPB; l_f = FLAGS_IN;
            {pend_res, pend_fl} = ref_op(OP, OPA, OPB, FLAGS_IN);
            start_c = cyc;
            due_c   = cyc + (OP[2] ? 2 : 1);
            active  = 1'b1;
        end
        if (active && (cyc == due_c)) begin
            held_res = pend_res;
            held_fl  = pend_fl;
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            logic [7:0] ea, eb;
            logic       ec, es;
            bit         lo_ph, hi_ph;
            lo_ph = active && (cyc == start_c);
            hi_ph = active && l_op[2] && (cyc == start_c + 1);
            ea = 8'h00; eb = 8'h00; ec = 1'b0; es = 1'b0;
            if (lo_ph) begin
                ea = l_a[7:0];
                eb = ((l_op == 3'd5) || (l_op == 3'd6)) ? 8'h01 : l_b[7:0];
                ec = ((l_op == 3'd1) || (l_op == 3'd3)) ? l_f[0] : 1'b0;
                es = (l_op == 3'd2) || (l_op == 3'd3) || (l_op == 3'd6);
            end else if (hi_ph) begin
                ea = l_a[15:8];
                es = (l_op == 3'd6);
                case (l_op)
                    3'd4: begin eb = l_b[15:8]; ec = (int'(l_a[7:0]) + int'(l_b[7:0])) > 255; end
                    3'd5: begin eb = 8'h00; ec = (l_a[7:0] == 8'hFF); end
                    3'd6: begin eb = 8'h00; ec = (l_a[7:0] == 8'h00); end
                    default: begin eb = {8{l_b[7]}}; ec = (int'(l_a[7:0]) + int'(l_b[7:0])) > 255; end
                endcase
            end
            chk("busy", 16'(BUSY), 16'(model_busy(cyc)));
            chk("done", 16'(DONE), 16'(active && (cyc == due_c)));
            chk("res", RES, held_res);
            chk("flags", 16'(FLAGS_OUT), 16'(held_fl));
            chk("alu_a", 16'(ALU_A), 16'(ea));
            chk("alu_b", 16'(ALU_B), 16'(eb));
            chk("alu_cin", 16'(ALU_CIN), 16'(ec));
            chk("alu_sub", 16'(ALU_SUB), 16'(es));
        end
    end

    // Directed request with hand-computed literal expectations; exp_lo_cs >= 0 also pins {CIN,SUB} in LO.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] f, input logic [15:0] er,
                          input logic [3:0] ef, input int elat, input int exp_lo_cs);
        int n;
        OP = op; OPA = a; OPB = b; FLAGS_IN = f; REQ = 1'b1;
        tick();
        REQ = 1'b0;
        n = 1;
        if (exp_lo_cs >= 0) chk({nm, " lo cin/sub"}, 16'({ALU_CIN, ALU_SUB}), 16'(exp_lo_cs));
        while (!DONE && (n < 8)) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, 16'(n), 16'(elat));
        chk({nm, " res"}, RES, er);
        chk({nm, " flags"}, 16'(FLAGS_OUT), 16'(ef));
        tick();
    endtask

    initial begin
        #2 nRESET = 1'b0;
        model_reset();
        #1 chk_en = 1'b1;
        repeat (3) tick();
        nRESET = 1'b1;
        tick();
        chk("reset busy", 16'(BUSY), 16'h0000);
        chk("reset res", RES, 16'h0000);
        chk("reset flags", 16'(FLAGS_OUT), 16'h0000);

        run_op("add8",    3'd0, 16'h003A, 16'h00C6, 4'h0, 16'h0000, 4'b1011, 2, 0);
        run_op("sbc8",    3'd3, 16'h0010, 16'h0001, 4'b0001, 16'h000E, 4'b0110, 2, 3);
        run_op("add16",   3'd4, 16'h8A23, 16'h0605, 4'b1010, 16'h9028, 4'b1010, 3, 0);
        run_op("dec16",   3'd6, 16'h0000, 16'h0000, 4'b0101, 16'hFFFF, 4'b0101, 3, 1);
        run_op("inc16",   3'd5, 16'hFFFF, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 3, 0);
        run_op("addsp m1", 3'd7, 16'h00FF, 16'h00FF, 4'b1111, 16'h00FE, 4'b0011, 3, 0);
        run_op("addsp p2", 3'd7, 16'hFFF8, 16'h0002, 4'b1111, 16'hFFFA, 4'b0000, 3, 0);

        // REQ during LO must be dropped.
        OP = 3'd0; OPA = 16'h003A; OPB = 16'h00C6; FLAGS_IN = 4'h0; REQ = 1'b1;
        tick();
        OP = 3'd2; OPA = 16'h0005; OPB = 16'h0009;
        tick();
        REQ = 1'b0;
        chk("ignore done", 16'(DONE), 16'h0001);
        chk("ignore res", RES, 16'h0000);
        chk("ignore flags", 16'(FLAGS_OUT), 16'(4'b1011));
        repeat (3) tick();

        // Reset during the HI pass of ADD16.
        OP = 3'd4; OPA = 16'h1234; OPB = 16'h1111; REQ = 1'b1;
        tick();
        REQ = 1'b0;
        tick();
        nRESET = 1'b0;
        model_reset();
        #1;
        chk("abort busy", 16'(BUSY), 16'h0000);
        chk("abort res", RES, 16'h0000);
        chk("abort alu_a", 16'(ALU_A), 16'h0000);
        repeat (2) tick();
        nRESET = 1'b1;
        repeat (3) tick();

        if (B2B) begin
            // Second request issued in the FIN cycle of the first.
            OP = 3'd0; OPA = 16'h0001; OPB = 16'h0002; REQ = 1'b1;
            tick();
            REQ = 1'b0;
            tick();
            OP = 3'd2; OPA = 16'h0010; OPB = 16'h0001; REQ = 1'b1;
            chk("b2b first done", 16'(DONE), 16'h0001);
            tick();
            REQ = 1'b0;
            tick();
            chk("b2b second done", 16'(DONE), 16'h0001);
            chk("b2b second res", RES, 16'h000F);
            repeat (2) tick();
        end

        // Randomized traffic with corner operands mixed in.
        repeat (600) begin
            OP       = 3'($urandom_range(0, 7));
            OPA      = 16'($urandom);
            OPB      = 16'($urandom);
            FLAGS_IN = 4'($urandom);
            if ($urandom_range(0, 5) == 0) OPA = 16'hFFFF;
            if ($urandom_range(0, 5) == 0) OPA = 16'h0000;
            if ($urandom_range(0, 5) == 0) OPB = 16'h00FF;
            REQ = ($urandom_range(0, 2) == 0);
            tick();
        end
        REQ = 1'b0;
        repeat (5) tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
